// File: rtl/lsu_mem_stage_pkg.sv
// Shared load/store definitions: Funct3 encodings, FSM states, byte-enable patterns
// and the access-size helpers used by the LSU and its lane logic.
package lsu_mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } lsuState_e;

    typedef enum logic [1:0] {
        ACC_BYTE,
        ACC_HALF,
        ACC_WORD
    } accSize_e;

    // Reserved encodings (011, 110, 111) fall through to a word access.
    function automatic accSize_e accessSize(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return ACC_BYTE;
            F3_H, F3_HU: return ACC_HALF;
            default:     return ACC_WORD;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLo);
        case (accessSize(funct3))
            ACC_HALF: return addrLo[0];
            ACC_WORD: return |addrLo;
            default:  return 1'b0;
        endcase
    endfunction

    // Low address bits that matter for the access size; the rest are forced to alignment.
    function automatic logic [1:0] alignedLane(input logic [2:0] funct3, input logic [1:0] addrLo);
        case (accessSize(funct3))
            ACC_BYTE: return addrLo;
            ACC_HALF: return {addrLo[1], 1'b0};
            default:  return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_stage_lane.sv
// lsu_lane: combinational byte-enable generation, store-data replication
// and load lane select with sign/zero extension.
module lsu_lane
    import lsu_mem_stage_pkg::*;
(
    input  logic [2:0]  storeFunct3,
    input  logic [1:0]  storeAddrLo,
    input  logic [31:0] storeData,
    output logic [3:0]  byteEn,
    output logic [31:0] storeWord,
    input  logic [2:0]  loadFunct3,
    input  logic [1:0]  loadAddrLo,
    input  logic [31:0] loadWord,
    output logic [31:0] loadResult
);

    logic [1:0]  storeLane;
    logic [1:0]  loadLane;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic        signFill;

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        storeLane = alignedLane(storeFunct3, storeAddrLo);
        byteEn    = BE_WORD;
        storeWord = storeData;
        case (accessSize(storeFunct3))
            ACC_BYTE: begin
                byteEn    = BE_BYTE << storeLane;
                storeWord = {4{storeData[7:0]}};
            end
            ACC_HALF: begin
                byteEn    = BE_HALF << storeLane;
                storeWord = {2{storeData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        loadLane   = alignedLane(loadFunct3, loadAddrLo);
        byteSel    = loadWord[8*loadLane +: 8];
        halfSel    = loadLane[1] ? loadWord[31:16] : loadWord[15:0];
        signFill   = 1'b0;
        loadResult = loadWord;
        case (accessSize(loadFunct3))
            ACC_BYTE: begin
                signFill   = ~loadFunct3[2] & byteSel[7];
                loadResult = {{24{signFill}}, byteSel};
            end
            ACC_HALF: begin
                signFill   = ~loadFunct3[2] & halfSel[15];
                loadResult = {{16{signFill}}, halfSel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: req/ack bus FSM with timeout abort and pipeline stall.
// Optional MISALIGN_TRAP_EN adds a Misaligned output and suppresses misaligned accesses.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadData,
    output logic        StallM,
    output logic        BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        Misaligned
`endif
);

    lsuState_e        state, stateNext;
    logic [CNT_W-1:0] reqCnt;
    logic             weQ;
    logic             loadQ;
    logic [2:0]       funct3Q;
    logic [1:0]       addrLoQ;
    logic             opValid;
    logic             trapOp;
    logic             startOp;
    logic             abortOp;
    logic [3:0]       laneBe;
    logic [31:0]      laneWdata;
    logic [31:0]      laneLoad;

    assign opValid = MemReadM | MemWriteM;

`ifdef MISALIGN_TRAP_EN
    assign trapOp     = opValid && isMisaligned(Funct3M, ALUResultM[1:0]);
    assign Misaligned = (state == IDLE) && trapOp;
`else
    assign trapOp = 1'b0;
`endif

    lsu_lane uLane (
        .storeFunct3 (Funct3M),
        .storeAddrLo (ALUResultM[1:0]),
        .storeData   (WriteDataM),
        .byteEn      (laneBe),
        .storeWord   (laneWdata),
        .loadFunct3  (funct3Q),
        .loadAddrLo  (addrLoQ),
        .loadWord    (bus_rdata),
        .loadResult  (laneLoad)
    );

    // StallM drops in DONE so the retiring instruction leaves MEM; its ops are ignored there.
    always_comb begin
        stateNext = state;
        StallM    = 1'b0;
        startOp   = 1'b0;
        abortOp   = 1'b0;
        case (state)
            IDLE: begin
                if (opValid && !trapOp) begin
                    startOp   = 1'b1;
                    StallM    = 1'b1;
                    stateNext = REQ;
                end
            end
            REQ: begin
                StallM = 1'b1;
                if (bus_ack) begin
                    stateNext = DONE;
                end else if (reqCnt == CNT_W'(TIMEOUT - 1)) begin
                    abortOp   = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign bus_req = (state == REQ);
    assign bus_we  = bus_req && weQ;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            reqCnt    <= '0;
            weQ       <= 1'b0;
            loadQ     <= 1'b0;
            funct3Q   <= '0;
            addrLoQ   <= '0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            ReadData  <= '0;
            BusErr    <= 1'b0;
        end else begin
            state  <= stateNext;
            BusErr <= abortOp;
            if (startOp) begin
                reqCnt    <= '0;
                bus_addr  <= {ALUResultM[31:2], 2'b00};
                bus_be    <= laneBe;
                bus_wdata <= laneWdata;
                weQ       <= MemWriteM;
                loadQ     <= ~MemWriteM;
                funct3Q   <= Funct3M;
                addrLoQ   <= ALUResultM[1:0];
            end else if (state == REQ) begin
                reqCnt <= reqCnt + 1'b1;
            end
            if (state == REQ && loadQ) begin
                if (bus_ack) begin
                    ReadData <= laneLoad;
                end else if (abortOp) begin
                    ReadData <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases plus randomized loads/stores
// compared every meaningful cycle against a transaction-level reference model.
module tb_lsu_mem_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadData;
    logic        StallM, BusErr;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
`ifdef MISALIGN_TRAP_EN
    logic        Misaligned;
`endif

    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] modelRead = '0;
    logic [31:0] lastAddr, lastWdata;
    logic [3:0]  lastBe;
    logic        lastWe;
    int          stallCycles, errPulses;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadData   (ReadData),
        .StallM     (StallM),
        .BusErr     (BusErr),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
`ifdef MISALIGN_TRAP_EN
        ,
        .Misaligned (Misaligned)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int accBytes(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic int laneOf(input logic [2:0] f3, input logic [31:0] addr);
        int n = accBytes(f3);
        return (int'(addr[1:0]) / n) * n;
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] addr);
        int n = accBytes(f3);
        return 4'(((1 << n) - 1) << laneOf(f3, addr));
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
        int n = accBytes(f3);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rd);
        int n = accBytes(f3);
        logic [31:0] v = rd >> (8 * laneOf(f3, addr));
        bit isSigned = (f3[2] == 1'b0);
        if (n == 4) return rd;
        if (n == 1) return (isSigned && v[7])  ? (v | 32'hFFFF_FF00) : (v & 32'h0000_00FF);
        return (isSigned && v[15]) ? (v | 32'hFFFF_0000) : (v & 32'h0000_FFFF);
    endfunction

    function automatic bit modelMisaligned(input logic [2:0] f3, input logic [31:0] addr);
        int n = accBytes(f3);
        return n > 1 && (int'(addr[1:0]) % n) != 0;
    endfunction

    // One complete transaction; ackDelay < 0 means the bus never answers.
    task automatic runOp(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int ackDelay);
        bit isLoad = rd && !wr;
        bit timedOut;
        stallCycles = 0;
        errPulses   = 0;
        @(posedge clk); #1;
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
        bus_ack = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (modelMisaligned(f3, addr)) begin
            @(negedge clk);
            check("mis_pulse", 32'(Misaligned), 32'd1);
            check("mis_stall", 32'(StallM), 32'd0);
            check("mis_req", 32'(bus_req), 32'd0);
            @(posedge clk); #1;
            MemReadM = 1'b0; MemWriteM = 1'b0;
            @(negedge clk);
            check("mis_after", 32'(Misaligned), 32'd0);
            check("mis_req2", 32'(bus_req), 32'd0);
            check("mis_rdata", ReadData, modelRead);
            return;
        end
`endif
        @(negedge clk);
        check("idle_stall", 32'(StallM), 32'd1);
        check("idle_req", 32'(bus_req), 32'd0);
        if (StallM) stallCycles++;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(posedge clk); #1;
            bus_ack   = (i == ackDelay);
            bus_rdata = bus_ack ? rdata : $urandom;
            @(negedge clk);
            check("req_req", 32'(bus_req), 32'd1);
            check("req_we", 32'(bus_we), 32'(wr));
            check("req_addr", bus_addr, {addr[31:2], 2'b00});
            check("req_be", 32'(bus_be), 32'(modelBe(f3, addr)));
            if (wr) check("req_wdata", bus_wdata, modelWdata(f3, wd));
            check("req_stall", 32'(StallM), 32'd1);
            if (StallM) stallCycles++;
            lastAddr = bus_addr; lastBe = bus_be; lastWdata = bus_wdata; lastWe = bus_we;
            if (bus_ack) break;
        end
        timedOut = (ackDelay < 0 || ackDelay >= TIMEOUT);
        if (isLoad) modelRead = timedOut ? 32'd0 : modelLoad(f3, addr, rdata);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check("done_stall", 32'(StallM), 32'd0);
        check("done_req", 32'(bus_req), 32'd0);
        check("done_buserr", 32'(BusErr), 32'(timedOut));
        check("done_rdata", ReadData, modelRead);
        errPulses += int'(BusErr);
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
        bus_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("gap_stall", 32'(StallM), 32'd0);
        check("gap_req", 32'(bus_req), 32'd0);
        check("gap_buserr", 32'(BusErr), 32'd0);
        check("gap_rdata", ReadData, modelRead);
        errPulses += int'(BusErr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, nChecks %0d", nChecks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = '0;
        ALUResultM = '0; WriteDataM = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", ReadData, 32'd0);
        check("rst_stall", 32'(StallM), 32'd0);
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_be", 32'(bus_be), 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_buserr", 32'(BusErr), 32'd0);
        #1 reset = 1'b0;

        // lw, ack in first REQ cycle
        runOp(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        check("t1_be", 32'(lastBe), 32'hF);
        check("t1_stall_cycles", 32'(stallCycles), 32'd2);
        check("t1_rdata", ReadData, 32'hDEADBEEF);

        // lb / lbu at byte lane 3
        runOp(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1);
        check("t2_be", 32'(lastBe), 32'h8);
        check("t2_lb", ReadData, 32'hFFFF_FF80);
        runOp(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 2);
        check("t2_lbu", ReadData, 32'h0000_0080);

        // sh upper half
        runOp(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0);
        check("t3_we", 32'(lastWe), 32'd1);
        check("t3_be", 32'(lastBe), 32'hC);
        check("t3_wdata", lastWdata, 32'hABCDABCD);
        check("t3_addr", lastAddr, 32'h200);
        check("t3_rdata_kept", ReadData, 32'h0000_0080);

        // timeout on a load
        runOp(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, -1);
        check("t4_err_pulses", 32'(errPulses), 32'd1);
        check("t4_stall_cycles", 32'(stallCycles), 32'(TIMEOUT + 1));
        check("t4_rdata", ReadData, 32'd0);

        // load and store both asserted -> store
        runOp(1'b1, 1'b1, 3'b000, 32'h401, 32'h0000_00A5, 32'h1111_1111, 0);
        check("both_we", 32'(lastWe), 32'd1);
        check("both_wdata", lastWdata, 32'hA5A5_A5A5);

        // reset in the middle of REQ after loading a non-zero value
        runOp(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h5555_AAAA, 0);
        @(posedge clk); #1;
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h504; bus_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; MemReadM = 1'b0;
        @(negedge clk);
        check("t5_req_before", 32'(bus_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_req", 32'(bus_req), 32'd0);
        check("t5_stall", 32'(StallM), 32'd0);
        check("t5_rdata", ReadData, 32'd0);
        modelRead = 32'd0;

`ifdef MISALIGN_TRAP_EN
        runOp(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
        check("t6_rdata", ReadData, 32'd0);
`endif

        for (int n = 0; n < 80; n++) begin
            int kind  = $urandom_range(0, 2);
            int delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            runOp(kind != 1, kind != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom, delay);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
